dmem_access_unit: RTL and testbench

//  Initiator side of the word-wide data-memory interface (address / writeData / memWrite /

---
 rtl/dmem_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Converts byte-addressed requests into word-indexed read / read-modify-write cycles.
module dmem_access_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_fault;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_writeData;
    logic        r_mem_memWrite;
    logic        r_mem_memRead;

    logic        w_handshake;
    logic        w_index_ok;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_word_store;

    assign w_handshake  = req_valid & r_req_ready;
    // Full upper address is compared so out-of-range bits fault instead of aliasing.
    assign w_index_ok   = ({2'b00, req_addr[31:2]} < MEM_WORDS);
    assign w_misaligned = ((req_size == 2'd1) & req_addr[0]) |
                          ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    assign w_fault      = (req_size == 2'd3) | w_misaligned | ~w_index_ok;
    assign w_word_store = req_write & (req_size == 2'd2);

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'd0:    result = sgn ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'h000000, shifted[7:0]};
            2'd1:    result = sgn ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] mask;
        logic [31:0] lane_mask;
        logic [31:0] lane_data;
        mask      = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = mask << {lane, 3'b000};
        lane_data = (wdata & mask) << {lane, 3'b000};
        return (word & ~lane_mask) | (lane_data & lane_mask);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_write         <= 1'b0;
            r_size          <= 2'd0;
            r_signed        <= 1'b0;
            r_lane          <= 2'd0;
            r_wdata         <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_fault    <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writeData <= '0;
            r_mem_memWrite  <= 1'b0;
            r_mem_memRead   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_lane      <= req_addr[1:0];
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= RESP;
                        end else begin
                            r_mem_address <= {2'b00, req_addr[31:2]};
                            if (w_word_store) begin
                                r_mem_writeData <= req_wdata;
                                r_mem_memWrite  <= 1'b1;
                                r_state         <= WRITE;
                            end else begin
                                r_mem_memRead <= 1'b1;
                                r_state       <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    r_mem_memRead <= 1'b0;
                    if (r_write) begin
                        r_mem_writeData <= store_merge(mem_readData, r_wdata, r_lane, r_size);
                        r_mem_memWrite  <= 1'b1;
                        r_state         <= WRITE;
                    end else begin
                        r_resp_rdata <= load_extract(mem_readData, r_lane, r_size, r_signed);
                        r_resp_fault <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WRITE: begin
                    r_mem_memWrite <= 1'b0;
                    r_resp_rdata   <= '0;
                    r_resp_fault   <= 1'b0;
                    r_resp_valid   <= 1'b1;
                    r_state        <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_mem_memRead  <= 1'b0;
                    r_mem_memWrite <= 1'b0;
                    r_resp_valid   <= 1'b0;
                    r_req_ready    <= 1'b1;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_fault    = r_resp_fault;
    assign mem_address   = r_mem_address;
    assign mem_writeData = r_mem_writeData;
    assign mem_memWrite  = r_mem_memWrite;
    assign mem_memRead   = r_mem_memRead;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed cases plus random requests checked against
// an arithmetic reference of memory contents, latency and extension rules.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    always #5 clk = ~clk;

    dmem_access_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
    );

    // Attached memory: combinational read, write on posedge while memWrite is high.
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;

    assign mem_readData = (mem_memRead && mem_address < 32'd256) ? mem[mem_address[7:0]] : '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_memWrite && mem_address < 32'd256) mem[mem_address[7:0]] <= mem_writeData;
    end

    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input int unsigned idx, input logic [31:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx[7:0];
        pl_val = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned idx;
        int unsigned shift;
        logic [31:0] mask, word, v;
        bit flt;
        int exp_lat, exp_rd, exp_wr, exp_wcyc;
        int got_lat, rd_cnt, wr_cnt, wcyc, w;
        logic [31:0] got_rdata;
        logic got_fault;

        idx   = addr >> 2;
        shift = (addr % 4) * 8;
        mask  = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        flt   = (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0) ||
                ((addr >> 2) >= 256);
        v = 32'd0; exp_rd = 0; exp_wr = 0; exp_wcyc = 0;
        if (flt) begin
            exp_lat = 1;
        end else begin
            word = ref_mem[idx];
            if (!wr) begin
                exp_lat = 2;
                exp_rd  = 1;
                v = (word >> shift) & mask;
                if (sz != 2 && sg && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
            end else begin
                exp_lat  = (sz == 2) ? 2 : 3;
                exp_rd   = (sz == 2) ? 0 : 1;
                exp_wr   = 1;
                exp_wcyc = (sz == 2) ? 1 : 2;
                ref_mem[idx] = (word & ~(mask << shift)) | ((wd & mask) << shift);
            end
        end

        @(negedge clk);
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        got_lat = 0; rd_cnt = 0; wr_cnt = 0; wcyc = 0; got_rdata = 'x; got_fault = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk({tag, "_rw_excl"}, {31'd0, mem_memRead & mem_memWrite}, 32'd0);
            if (mem_memRead) rd_cnt++;
            if (mem_memWrite) begin
                wr_cnt++;
                wcyc = k;
            end
            if (resp_valid) begin
                got_lat   = k;
                got_rdata = resp_rdata;
                got_fault = resp_fault;
                break;
            end
        end
        chk({tag, "_latency"}, got_lat, exp_lat);
        chk({tag, "_fault"}, {31'd0, got_fault}, {31'd0, flt});
        chk({tag, "_rdata"}, got_rdata, v);
        chk({tag, "_reads"}, rd_cnt, exp_rd);
        chk({tag, "_writes"}, wr_cnt, exp_wr);
        if (exp_wr != 0) begin
            chk({tag, "_wcycle"}, wcyc, exp_wcyc);
            chk({tag, "_memword"}, mem[idx], ref_mem[idx]);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_memWrite", {31'd0, mem_memWrite}, 32'd0);
        chk("rst_memRead", {31'd0, mem_memRead}, 32'd0);
        chk("rst_address", mem_address, 32'd0);
        chk("rst_writeData", mem_writeData, 32'd0);

        for (int i = 0; i < 256; i++) preload(i, $urandom);
        preload(4, 32'h8899AABB);
        preload(3, 32'h11223344);
        @(negedge clk);
        reset = 1'b0;

        do_req("t1_lb_signed", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        do_req("t2_lh_unsigned", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_req("t2_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req("t3_sb", 1'b1, 2'd0, 1'b0, 32'h0E, 32'hEE);
        chk("t3_mem3_literal", mem[3], 32'h11EE3344);
        do_req("t4_sw", 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("t4_mem8_literal", mem[8], 32'hDEADBEEF);
        do_req("t5_lw_misaligned", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
        do_req("t5_sh_misaligned", 1'b1, 2'd1, 1'b0, 32'h05, 32'h1234);
        do_req("t5_load_oob", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        do_req("size3_fault", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        do_req("sh_top_lane", 1'b1, 2'd1, 1'b0, 32'h3FE, 32'hA5A5);
        do_req("lh_signed_top", 1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0);

        // Reset during the READ cycle of a sub-word store must drop it.
        preload(5, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_read", {31'd0, mem_memRead}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_ready_next", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t6_no_write", {31'd0, mem_memWrite}, 32'd0);
            chk("t6_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("t6_mem_untouched", mem[5], 32'hCAFEF00D);
        do_req("t6_recover_lw", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h400 + ($urandom & 32'h0FFF_FFFF);
            else a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
            do_req($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom_range(0, 3)),
                   1'($urandom), a, $urandom);
        end

        for (int i = 0; i < 256; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
